// File: rtl/dsp_issue_ctrl.sv
// Issue/hazard controller between decode and execute: per-register write-back
// scoreboard, RAW/WAW stall generation and branch/jump flow sequencing.
module dsp_issue_ctrl #(
  parameter int ALU_LAT = 3,
  parameter int LD_LAT  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [4:0]  dec_reg_addr1,
  input  logic [4:0]  dec_reg_addr2,
  input  logic [4:0]  dec_reg_addr3,
  input  logic [2:0]  dec_src_used,
  input  logic        dec_wb_en,
  input  logic [4:0]  dec_reg_dest,
  input  logic [2:0]  dec_mem_mode,
  input  logic [2:0]  dec_flow_mode,
  input  logic        mem_busy,
  input  logic        br_resolved,
  input  logic        br_taken,
  output logic        stall,
  output logic        issue,
  output logic        flush,
  output logic [31:0] busy_map
);

  localparam logic [2:0] MEM_LD    = 3'd1;
  localparam logic [2:0] FLOW_JMP  = 3'd1;
  localparam logic [2:0] FLOW_BEZ  = 3'd2;
  localparam logic [2:0] FLOW_BNEZ = 3'd3;
  localparam logic [2:0] FLOW_BEQ  = 3'd4;

  typedef enum logic [1:0] {S_RUN, S_BR_WAIT, S_FLUSH} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt [32];
  logic       raw_haz, waw_haz, hazard;
  logic [2:0] wb_lat;

  function automatic logic is_cond_branch(input logic [2:0] flow);
    return (flow == FLOW_BEZ) || (flow == FLOW_BNEZ) || (flow == FLOW_BEQ);
  endfunction

  // A source becomes readable in the cycle its counter reaches 1 (the write
  // lands at that edge), so a consumer can issue exactly L cycles after the
  // producer. A second writer still waits for the counter to drain fully.
  function automatic logic src_pending(input logic [2:0] c);
    return c > 3'd1;
  endfunction

  always_comb begin
    raw_haz = (dec_src_used[0] && src_pending(cnt[dec_reg_addr1])) ||
              (dec_src_used[1] && src_pending(cnt[dec_reg_addr2])) ||
              (dec_src_used[2] && src_pending(cnt[dec_reg_addr3]));
    waw_haz = dec_wb_en && (cnt[dec_reg_dest] != 3'd0);
    hazard  = raw_haz || waw_haz;
    wb_lat  = (dec_mem_mode == MEM_LD) ? 3'(LD_LAT) : 3'(ALU_LAT);
  end

  always_comb begin
    busy_map = '0;
    for (int r = 0; r < 32; r++) busy_map[r] = (cnt[r] != 3'd0);
  end

  // Scoreboard: frozen while memory is busy, load overrides the decrement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < 32; r++) cnt[r] <= 3'd0;
    end else if (!mem_busy) begin
      for (int r = 0; r < 32; r++) begin
        if (issue && dec_wb_en && (dec_reg_dest == 5'(r)))
          cnt[r] <= wb_lat;
        else if (cnt[r] != 3'd0)
          cnt[r] <= cnt[r] - 3'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (issue && (dec_flow_mode == FLOW_JMP))   state_nxt = S_FLUSH;
        else if (issue && is_cond_branch(dec_flow_mode)) state_nxt = S_BR_WAIT;
      end
      S_BR_WAIT: begin
        if (br_resolved) state_nxt = br_taken ? S_FLUSH : S_RUN;
      end
      S_FLUSH:  state_nxt = S_RUN;
      default:  state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    if (rst_n) begin
      case (state)
        S_RUN: begin
          issue = dec_valid && !hazard && !mem_busy;
          stall = dec_valid && (hazard || mem_busy);
        end
        S_BR_WAIT: stall = 1'b1;
        S_FLUSH:   flush = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_issue_ctrl.sv
// Self-checking bench for dsp_issue_ctrl: directed timing scenarios plus
// randomized traffic compared against a timestamp-based reference model.
module tb_dsp_issue_ctrl;

  localparam int ALU_LAT = 3;
  localparam int LD_LAT  = 4;
  localparam logic [2:0] MEM_NONE  = 3'd0;
  localparam logic [2:0] MEM_LD    = 3'd1;
  localparam logic [2:0] FLOW_NONE = 3'd0;
  localparam logic [2:0] FLOW_JMP  = 3'd1;
  localparam logic [2:0] FLOW_BEZ  = 3'd2;
  localparam logic [2:0] FLOW_BNEZ = 3'd3;
  localparam logic [2:0] FLOW_BEQ  = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid;
  logic [4:0]  dec_reg_addr1, dec_reg_addr2, dec_reg_addr3, dec_reg_dest;
  logic [2:0]  dec_src_used, dec_mem_mode, dec_flow_mode;
  logic        dec_wb_en, mem_busy, br_resolved, br_taken;
  logic        stall, issue, flush;
  logic [31:0] busy_map;

  int errors = 0;
  int checks = 0;

  // Model: ready_at[r] is the unfrozen-cycle number at which r's pending value
  // becomes readable; ecyc counts only cycles in which memory was not busy.
  int ready_at [32];
  int ecyc;
  bit wait_br, kill;
  logic       m_issue, m_stall, m_flush;
  logic [31:0] m_busy;

  dsp_issue_ctrl #(.ALU_LAT(ALU_LAT), .LD_LAT(LD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid),
    .dec_reg_addr1(dec_reg_addr1), .dec_reg_addr2(dec_reg_addr2),
    .dec_reg_addr3(dec_reg_addr3), .dec_src_used(dec_src_used),
    .dec_wb_en(dec_wb_en), .dec_reg_dest(dec_reg_dest),
    .dec_mem_mode(dec_mem_mode), .dec_flow_mode(dec_flow_mode),
    .mem_busy(mem_busy), .br_resolved(br_resolved), .br_taken(br_taken),
    .stall(stall), .issue(issue), .flush(flush), .busy_map(busy_map)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) ready_at[r] = -1000;
    ecyc = 0;
    wait_br = 0;
    kill = 0;
  endtask

  task automatic model_eval();
    bit raw, waw;
    raw = (dec_src_used[0] && ecyc < ready_at[dec_reg_addr1]) ||
          (dec_src_used[1] && ecyc < ready_at[dec_reg_addr2]) ||
          (dec_src_used[2] && ecyc < ready_at[dec_reg_addr3]);
    waw = dec_wb_en && (ecyc <= ready_at[dec_reg_dest]);
    for (int r = 0; r < 32; r++) m_busy[r] = (ecyc <= ready_at[r]);
    m_issue = 0; m_stall = 0; m_flush = 0;
    if (!rst_n) m_busy = '0;
    else if (kill) m_flush = 1;
    else if (wait_br) m_stall = 1;
    else begin
      m_issue = dec_valid && !raw && !waw && !mem_busy;
      m_stall = dec_valid && (raw || waw || mem_busy);
    end
  endtask

  task automatic model_advance();
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (kill) kill = 0;
    else if (wait_br) begin
      if (br_resolved) begin
        wait_br = 0;
        kill = br_taken;
      end
    end else if (m_issue) begin
      if (dec_flow_mode == FLOW_JMP) kill = 1;
      else if (dec_flow_mode inside {FLOW_BEZ, FLOW_BNEZ, FLOW_BEQ}) wait_br = 1;
    end
    if (!mem_busy) begin
      if (m_issue && dec_wb_en)
        ready_at[dec_reg_dest] = ecyc + ((dec_mem_mode == MEM_LD) ? LD_LAT : ALU_LAT);
      ecyc++;
    end
  endtask

  task automatic set_in(input logic v, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] a3, input logic [2:0] used, input logic wb,
                        input logic [4:0] dest, input logic [2:0] mm, input logic [2:0] fm,
                        input logic mb, input logic brr, input logic brt);
    dec_valid = v; dec_reg_addr1 = a1; dec_reg_addr2 = a2; dec_reg_addr3 = a3;
    dec_src_used = used; dec_wb_en = wb; dec_reg_dest = dest;
    dec_mem_mode = mm; dec_flow_mode = fm; mem_busy = mb;
    br_resolved = brr; br_taken = brt;
    #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
  endtask

  // Compare all outputs with the model, then advance one clock.
  task automatic step(input string tag);
    model_eval();
    chk({tag, ".issue"}, 32'(issue), 32'(m_issue));
    chk({tag, ".stall"}, 32'(stall), 32'(m_stall));
    chk({tag, ".flush"}, 32'(flush), 32'(m_flush));
    chk({tag, ".busy"}, busy_map, m_busy);
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic randomize_in();
    logic [2:0] fm;
    int f;
    f = $urandom_range(0, 19);
    fm = (f == 0) ? FLOW_JMP : (f == 1) ? FLOW_BEZ : (f == 2) ? FLOW_BNEZ :
         (f == 3) ? FLOW_BEQ : FLOW_NONE;
    set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 3'($urandom), ($urandom_range(0, 4) < 3),
           5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0) ? MEM_LD : 3'($urandom_range(2, 7)),
           fm, ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0), 1'($urandom));
  endtask

  initial begin
    model_reset();
    rst_n = 0;
    // Outputs must stay quiet during reset whatever decode presents
    for (int i = 0; i < 4; i++) begin
      randomize_in();
      chk("rst.issue", 32'(issue), 0);
      chk("rst.stall", 32'(stall), 0);
      chk("rst.flush", 32'(flush), 0);
      chk("rst.busy", busy_map, 0);
      @(posedge clk); #1;
    end
    idle();
    rst_n = 1;
    @(posedge clk); #1;

    // ADD r1,r2->r3 then SUB reading r3: issue at t+3
    set_in(1, 1, 2, 0, 3'b011, 1, 3, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("add.issue", 32'(issue), 1);
    step("add");
    set_in(1, 3, 4, 0, 3'b011, 1, 6, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("add.busy_map", busy_map, 32'h8);
    chk("raw.stall1", 32'(stall), 1);
    step("raw1");
    chk("raw.stall2", 32'(stall), 1);
    step("raw2");
    chk("raw.issue3", 32'(issue), 1);
    step("raw3");
    idle(); repeat (4) step("drain");

    // LD ->r5, consumer of r5 issues at t+4
    set_in(1, 1, 0, 0, 3'b001, 1, 5, MEM_LD, FLOW_NONE, 0, 0, 0);
    step("ld");
    set_in(1, 0, 5, 0, 3'b010, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      chk("ld.stall", 32'(stall), 1);
      step("ldw");
    end
    chk("ld.issue4", 32'(issue), 1);
    step("ld4");
    idle(); repeat (5) step("drain");

    // r31 pending: unused addr2=r31 does not stall, MAC using all sources does
    set_in(1, 1, 0, 0, 3'b001, 1, 31, MEM_NONE, FLOW_NONE, 0, 0, 0);
    step("p31");
    set_in(1, 0, 31, 0, 3'b001, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("unused.issue", 32'(issue), 1);
    step("unused");
    set_in(1, 1, 2, 31, 3'b111, 1, 7, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("mac.stall", 32'(stall), 1);
    step("mac1");
    chk("mac.issue", 32'(issue), 1);
    step("mac2");
    idle(); repeat (4) step("drain");

    // Taken branch: resolve at t+3, flush at t+4, issue at t+5
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_BEZ, 0, 0, 0);
    step("bez");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    for (int k = 1; k <= 2; k++) begin
      chk("br.stall", 32'(stall), 1);
      chk("br.noissue", 32'(issue), 0);
      step("brw");
    end
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 1, 1, 1);
    chk("br.stall3", 32'(stall), 1);
    step("brres");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("br.flush", 32'(flush), 1);
    chk("br.flush_nostall", 32'(stall), 0);
    step("brfl");
    chk("br.resume", 32'(issue), 1);
    step("brrun");

    // Not-taken branch: no flush, fall-through issues at t+4
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_BNEZ, 0, 0, 0);
    step("bnez");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    repeat (2) step("ntw");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 1, 0);
    step("ntres");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("nt.noflush", 32'(flush), 0);
    chk("nt.issue", 32'(issue), 1);
    step("ntrun");

    // JMP: single flush cycle; stray resolve in RUN is ignored
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_JMP, 0, 0, 0);
    step("jmp");
    idle();
    chk("jmp.flush1", 32'(flush), 1);
    step("jmpf");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_NONE, 0, 1, 1);
    chk("jmp.flush2", 32'(flush), 0);
    step("stray");
    idle();
    chk("stray.noflush", 32'(flush), 0);
    step("stray2");

    // mem_busy freezes the scoreboard: SUB issues at t+5 instead of t+3
    set_in(1, 1, 2, 0, 3'b011, 1, 3, MEM_NONE, FLOW_NONE, 0, 0, 0);
    step("add2");
    set_in(1, 3, 0, 0, 3'b001, 0, 0, MEM_NONE, FLOW_NONE, 1, 0, 0);
    repeat (2) begin
      chk("mb.noissue", 32'(issue), 0);
      chk("mb.busy3", 32'(busy_map[3]), 1);
      step("mb");
    end
    set_in(1, 3, 0, 0, 3'b001, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    repeat (2) begin
      chk("mb.held", 32'(stall), 1);
      step("mbh");
    end
    chk("mb.issue", 32'(issue), 1);
    step("mbi");

    // Reset asserted mid-BR_WAIT clears state and scoreboard at once
    set_in(1, 1, 0, 0, 3'b001, 1, 9, MEM_NONE, FLOW_NONE, 0, 0, 0);
    step("add9");
    set_in(1, 0, 0, 0, 3'b000, 0, 0, MEM_NONE, FLOW_BEQ, 0, 0, 0);
    step("beq");
    idle();
    chk("bw.stall", 32'(stall), 1);
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("arst.busy", busy_map, 0);
    chk("arst.stall", 32'(stall), 0);
    chk("arst.flush", 32'(flush), 0);
    #2 rst_n = 1;
    set_in(1, 9, 0, 0, 3'b001, 0, 0, MEM_NONE, FLOW_NONE, 0, 0, 0);
    chk("arst.run_issue", 32'(issue), 1);
    step("post");

    // Randomized traffic, with occasional reset pulses
    for (int i = 0; i < 3000; i++) begin
      randomize_in();
      if ($urandom_range(0, 499) == 0) rst_n = 0;
      else rst_n = 1;
      #1;
      step("rnd");
    end
    rst_n = 1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
